// File: rtl/cpu_pkg.sv
// Shared widths, halt sentinel and FSM state encoding for the instruction fetch controller.
package cpu_pkg;
  localparam int unsigned INST_W_DEF = 32;
  localparam int unsigned PC_W_DEF   = 5;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/imem_sync.sv
// Instruction store: one write port, one synchronous read port (data valid one cycle after address).
// Contents are never reset; read returns the old word when read and write hit the same address.
module imem_sync #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch controller: run in IDLE -> inst_valid two cycles later, one instruction per two cycles.
// inst/inst_valid hold until inst_ready; redirects restart fetch; the halt word parks the FSM in HALT.
module inst_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned      INST_W    = INST_W_DEF,
  parameter int unsigned      PC_W      = PC_W_DEF,
  parameter logic [INST_W-1:0] HALT_WORD = INST_W'(HALT_WORD_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              load_en,
  input  logic [PC_W-1:0]   load_addr,
  input  logic [INST_W-1:0] load_data,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect_en,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic [15:0]       issued_cnt
);
  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [INST_W-1:0] rdata;
  logic              mem_we;
  logic              fire;

  // Read address tracks the next pc so the word for pc_q is ready during FETCH.
  imem_sync #(.DW(INST_W), .AW(PC_W)) u_imem (
    .clk   (clk),
    .we    (mem_we & ~rst),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc_d),
    .rdata (rdata)
  );

  assign fire = inst_valid_q & inst_ready;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    cnt_d        = cnt_q;
    mem_we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        mem_we = load_en;
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (redirect_en) begin
          pc_d = redirect_pc;
        end else begin
          state_d      = S_ISSUE;
          inst_d       = rdata;
          inst_valid_d = (rdata != HALT_WORD);
        end
      end
      S_ISSUE: begin
        if (fire) begin
          inst_valid_d = 1'b0;
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          if (redirect_en) begin
            pc_d    = redirect_pc;
            state_d = S_FETCH;
          end else begin
            pc_d    = pc_q + PC_W'(1);
            state_d = run ? S_FETCH : S_IDLE;
          end
        end else if (redirect_en) begin
          inst_valid_d = 1'b0;
          pc_d         = redirect_pc;
          state_d      = S_FETCH;
        end else if (inst_q == HALT_WORD) begin
          state_d = S_HALT;
        end
      end
      S_HALT: inst_valid_d = 1'b0;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign pc         = pc_q;
  assign halted     = (state_q == S_HALT);
  assign issued_cnt = cnt_q;
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench: program loads, issue ordering via an expected-instruction queue, stalls, redirects, wrap, reset.
module tb_inst_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst, run, load_en, inst_ready, redirect_en, inst_valid, halted;
  logic [4:0]  load_addr, redirect_pc, pc;
  logic [31:0] load_data, inst;
  logic [15:0] issued_cnt;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  logic [31:0] mem [32];
  logic [31:0] exp_q [$];
  logic [31:0] held;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  always #5 clk = ~clk;

  inst_fetch_ctrl dut (
    .clk(clk), .rst(rst), .run(run), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .pc(pc), .halted(halted),
    .issued_cnt(issued_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic load(input int addr, input logic [31:0] data);
    load_en = 1'b1; load_addr = 5'(addr); load_data = data;
    tick();
    load_en = 1'b0;
    mem[addr] = data;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (inst_valid !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    if (inst_valid !== 1'b1) check({tag, "_timeout"}, 32'(inst_valid), 32'd1);
  endtask

  // Waits for the next valid instruction, compares it with the queue head, lets the handshake happen.
  task automatic expect_issue(input string tag, input int exp_pc);
    logic [31:0] e;
    wait_valid(tag);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_0000;
    check({tag, "_inst"}, inst, e);
    check({tag, "_pc"}, 32'(pc), 32'(exp_pc));
    tick();
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    inst_ready = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
    tick(); tick();
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_cnt", 32'(issued_cnt), 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 32; k++) load(k, 32'hA000_0000 + 32'(k));
    load(0, 32'h0001_0820);
    load(1, 32'h0020_0822);
    load(2, HALT);

    // Program with halt: two issues then HALT; also checks two-cycle start latency.
    exp_q.push_back(mem[0]);
    exp_q.push_back(mem[1]);
    run = 1'b1; inst_ready = 1'b1;
    tick();
    check("lat_cyc1_valid", 32'(inst_valid), 32'd0);
    tick();
    check("lat_cyc2_valid", 32'(inst_valid), 32'd1);
    expect_issue("prog_i0", 0);
    expect_issue("prog_i1", 1);
    for (int n = 0; n < 12 && halted !== 1'b1; n++) tick();
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_cnt", 32'(issued_cnt), 32'd2);
    check("halt_pc", 32'(pc), 32'd2);
    check("halt_valid", 32'(inst_valid), 32'd0);
    tick(); tick();
    check("halt_sticky", 32'(halted), 32'd1);

    // Reset out of HALT; memory persists, replace the halt word.
    rst = 1'b1; run = 1'b0; inst_ready = 1'b0;
    tick();
    rst = 1'b0;
    check("rst2_halted", 32'(halted), 32'd0);
    load(2, 32'hA000_0002);

    // Stall for five cycles.
    exp_q.push_back(mem[0]);
    run = 1'b1;
    wait_valid("stall");
    held = exp_q.pop_front();
    check("stall_inst0", inst, held);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_inst", inst, held);
      check("stall_valid", 32'(inst_valid), 32'd1);
      check("stall_pc", 32'(pc), 32'd0);
      check("stall_cnt", 32'(issued_cnt), 32'd0);
    end
    inst_ready = 1'b1;
    tick();
    check("accept_cnt", 32'(issued_cnt), 32'd1);
    check("accept_pc", 32'(pc), 32'd1);
    check("accept_valid", 32'(inst_valid), 32'd0);
    // Now in FETCH: this write must be ignored.
    load_en = 1'b1; load_addr = 5'd5; load_data = 32'hDEAD_BEEF;
    tick();
    load_en = 1'b0;

    exp_q.push_back(mem[1]);
    exp_q.push_back(mem[2]);
    expect_issue("seq_i1", 1);
    expect_issue("seq_i2", 2);

    // Redirect coincident with handshake at pc=3.
    wait_valid("redir");
    check("redir_pc3", 32'(pc), 32'd3);
    check("redir_inst3", inst, mem[3]);
    redirect_en = 1'b1; redirect_pc = 5'd20;
    tick();
    redirect_en = 1'b0;
    check("redir_cnt", 32'(issued_cnt), 32'd4);
    check("redir_valid", 32'(inst_valid), 32'd0);
    check("redir_pc", 32'(pc), 32'd20);

    // Run 20..31, wrap to 0, continue to 5 (verifies the FETCH-time write was dropped).
    for (int k = 20; k < 32; k++) exp_q.push_back(mem[k]);
    for (int k = 0; k < 6; k++) exp_q.push_back(mem[k]);
    for (int k = 20; k < 32; k++) expect_issue("walk", k);
    for (int k = 0; k < 6; k++) expect_issue("wrap", k);
    check("walk_cnt", 32'(issued_cnt), 32'd22);

    // Reset mid-ISSUE.
    inst_ready = 1'b0;
    wait_valid("rstmid");
    rst = 1'b1; run = 1'b0;
    tick();
    rst = 1'b0;
    check("rstmid_valid", 32'(inst_valid), 32'd0);
    check("rstmid_pc", 32'(pc), 32'd0);
    check("rstmid_cnt", 32'(issued_cnt), 32'd0);
    tick(); tick();
    check("rstmid_idle", 32'(inst_valid), 32'd0);

    // run dropped during ISSUE: hold, accept, then go IDLE.
    run = 1'b1;
    wait_valid("rundrop");
    run = 1'b0;
    tick();
    check("rundrop_hold", 32'(inst_valid), 32'd1);
    check("rundrop_inst", inst, mem[0]);
    inst_ready = 1'b1;
    tick();
    check("rundrop_cnt", 32'(issued_cnt), 32'd1);
    tick(); tick(); tick();
    check("rundrop_idle_valid", 32'(inst_valid), 32'd0);
    check("rundrop_idle_pc", 32'(pc), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
